// File: rtl/spiketpu_pkg.sv
// spiketpu_pkg: shared FSM state encoding and default widths for the spike-count collector.
package spiketpu_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;
    localparam int DEF_NUM_PE = 8;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_TS_W   = 16;
endpackage

// File: rtl/spike_lane_counter.sv
// spike_lane_counter: one lane's spike counter with synchronous clear and enable.
// Defining SPIKE_COUNT_SATURATE_EN makes it hold at all-ones instead of wrapping.
module spike_lane_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
`ifdef SPIKE_COUNT_SATURATE_EN
        cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`else
        cnt_d = clr_i ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/spike_count_collector.sv
// spike_count_collector: counts per-lane PE spikes over a window of timesteps, then drains
// one (index, count) result per lane over a valid/ready handshake. Option: SPIKE_COUNT_SATURATE_EN.
module spike_count_collector
    import spiketpu_pkg::*;
#(
    parameter int  NUM_PE = DEF_NUM_PE,
    parameter int  CNT_W  = DEF_CNT_W,
    parameter int  TS_W   = DEF_TS_W,
    localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [TS_W-1:0]   num_steps,
    input  logic [NUM_PE-1:0] in_spikes,
    input  logic              in_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy,
    output logic              done
);
    state_t           state_q, state_d;
    logic [TS_W-1:0]  steps_q, steps_d, len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt [NUM_PE];
    logic             clr, last;

    assign clr  = (state_q == IDLE) && start;
    assign last = idx_q == IDX_W'(NUM_PE - 1);

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        spike_lane_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rstn    (rstn),
            .clr_i   (clr),
            .en_i    ((state_q == ACCUM) && in_valid && in_spikes[i]),
            .count_o (cnt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                steps_d = '0;
                len_d   = num_steps;
                idx_d   = '0;
                state_d = (num_steps == '0) ? DRAIN : ACCUM;
            end
            ACCUM: if (in_valid) begin
                steps_d = steps_q + TS_W'(1);
                state_d = (steps_d == len_q) ? DRAIN : ACCUM;
            end
            DRAIN: if (out_ready) begin
                idx_d   = last ? '0 : idx_q + IDX_W'(1);
                state_d = last ? IDLE : DRAIN;
                done_d  = last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            steps_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = state_q == DRAIN;
    assign out_idx   = idx_q;
    assign out_count = cnt[idx_q];
    assign busy      = state_q != IDLE;
    assign done      = done_q;
endmodule

// File: tb/tb_spike_count_collector.sv
// tb_spike_count_collector: directed table-driven bench for spike_count_collector.
module tb_spike_count_collector;
    typedef struct {
        logic [15:0]     ns;
        int              nsteps;
        logic [7:0][7:0] spk;
        int              gaps;
        logic [3:0]      rdy;
        logic [7:0][7:0] exp;
    } vec_t;

    logic            clk = 0, rstn = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [15:0]     num_steps = 0;
    logic [7:0]      in_spikes = 0;
    logic            out_valid, busy, done;
    logic [2:0]      out_idx;
    logic [7:0]      out_count;
    int              checks = 0, failures = 0;
    vec_t            vecs [5];
    logic [7:0][7:0] e;

    spike_count_collector dut (
        .clk(clk), .rstn(rstn), .start(start), .num_steps(num_steps),
        .in_spikes(in_spikes), .in_valid(in_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_count(out_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Entered at a negedge where DRAIN is (or is about to be) active; ends one cycle after done.
    task automatic drain(input logic [3:0] rdy, input logic [7:0][7:0] exp, input bit b2b);
        int n = 0;
        int cyc = 0;
        while (n < 8 && cyc < 64) begin
            out_ready = rdy[cyc[1:0]];
            if (out_valid) begin
                chk("drain_idx", 32'(out_idx), n);
                chk("drain_count", 32'(out_count), 32'(exp[n[2:0]]));
                if (out_ready) n++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 0;
        chk("transfers", n, 8);
        chk("done_pulse", 32'(done), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        if (b2b) begin
            start = 1;
            num_steps = 1;
        end
        @(negedge clk);
        start = 0;
        chk("done_drop", 32'(done), 0);
    endtask

    task automatic run_window(input vec_t v, input bit b2b);
        @(negedge clk);
        start = 1;
        num_steps = v.ns;
        @(negedge clk);
        start = 0;
        num_steps = 16'hFFFF;
        for (int k = 0; k < v.nsteps; k++) begin
            chk("accum_busy", 32'(busy), 1);
            chk("accum_out_valid", 32'(out_valid), 0);
            in_valid = 1;
            in_spikes = v.spk[k % 8];
            @(negedge clk);
            in_valid = 0;
            in_spikes = 8'hFF;
            if (k != v.nsteps - 1) repeat (v.gaps) @(negedge clk);
        end
        drain(v.rdy, v.exp, b2b);
    endtask

    function automatic logic [7:0][7:0] fill(input logic [7:0] val);
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++) r[i] = val;
        return r;
    endfunction

    initial begin
        vecs[0] = '{ns: 4, nsteps: 4, spk: fill(8'hFF), gaps: 0, rdy: 4'b1111, exp: fill(8'd4)};
        e = fill(0); e[0] = 3; e[1] = 1; e[7] = 1;
        vecs[1] = '{ns: 3, nsteps: 3, spk: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h03, 8'h01},
                    gaps: 2, rdy: 4'b1111, exp: e};
        e = {8'd2, 8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        vecs[2] = '{ns: 2, nsteps: 2, spk: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hA5},
                    gaps: 0, rdy: 4'b1001, exp: e};
        vecs[3] = '{ns: 0, nsteps: 0, spk: fill(8'hFF), gaps: 0, rdy: 4'b0110, exp: fill(8'd0)};
        e = fill(0);
`ifdef SPIKE_COUNT_SATURATE_EN
        e[0] = 8'd255;
`else
        e[0] = 8'd44;
`endif
        vecs[4] = '{ns: 300, nsteps: 300, spk: fill(8'h01), gaps: 0, rdy: 4'b1111, exp: e};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_idx", 32'(out_idx), 0);
        rstn = 1;

        for (int v = 0; v < 5; v++) run_window(vecs[v], 1'b0);

        // back-to-back: start lands in the done cycle
        run_window(vecs[0], 1'b1);
        chk("b2b_busy", 32'(busy), 1);
        in_valid = 1;
        in_spikes = 8'h80;
        @(negedge clk);
        in_valid = 0;
        e = fill(0); e[7] = 1;
        drain(4'b1111, e, 1'b0);

        // start during ACCUM must not relatch length or clear counters
        @(negedge clk);
        start = 1; num_steps = 3;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_spikes = 8'hFF;
        @(negedge clk);
        in_valid = 0; start = 1; num_steps = 1;
        @(negedge clk);
        start = 0; num_steps = 0;
        chk("ign_busy", 32'(busy), 1);
        in_valid = 1;
        @(negedge clk);
        chk("ign_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 0;
        drain(4'b1111, fill(8'd3), 1'b0);

        // asynchronous reset mid-ACCUM
        @(negedge clk);
        start = 1; num_steps = 5;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_spikes = 8'hFF;
        repeat (2) @(negedge clk);
        #2 rstn = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_idx", 32'(out_idx), 0);
        @(negedge clk);
        in_valid = 0;
        rstn = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(out_valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        vecs[0].ns = 2; vecs[0].nsteps = 2; vecs[0].exp = fill(8'd2);
        run_window(vecs[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spike_count_collector.md
SPIKE_COUNT_COLLECTOR -- requirements
Module: spike_count_collector

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 8, giving the number of PE out_spike lanes collected.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the per-lane spike-count width.
REQ-003 The block SHALL have parameter TS_W, default 16, giving the timestep-count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a collection window.
REQ-007 The block SHALL have port num_steps, input, TS_W bits: window length in timesteps, sampled on accepted start.
REQ-008 The block SHALL have port in_spikes, input, NUM_PE bits: registered out_spike of each PE, bit i = lane i.
REQ-009 The block SHALL have port in_valid, input, 1 bit: in_spikes holds one timestep's spikes this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_idx/out_count hold a valid result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 The block SHALL have port out_idx, output, clog2(NUM_PE) bits: lane index of the current result.
REQ-013 The block SHALL have port out_count, output, CNT_W bits: spike count of lane out_idx.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last lane is accepted.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DRAIN.
REQ-017 In IDLE, start=1 SHALL clear all lane counters, clear the step counter, latch num_steps, and enter ACCUM next cycle; if num_steps=0 it SHALL enter DRAIN instead.
REQ-018 start SHALL be ignored in ACCUM and DRAIN.
REQ-019 In ACCUM, each cycle with in_valid=1 SHALL add in_spikes[i] (0/1) to counter i for every lane and increment the step counter.
REQ-020 ACCUM SHALL enter DRAIN on the cycle after the accepted timestep that makes the step count equal the latched num_steps.
REQ-021 in_valid and in_spikes SHALL be ignored outside ACCUM, and counters SHALL hold when in_valid=0.
REQ-022 In DRAIN, out_valid SHALL be 1, out_idx SHALL start at 0, and out_count SHALL equal counter[out_idx] combinationally from registered state.
REQ-023 out_idx SHALL advance only on out_valid&&out_ready, and out_idx/out_count SHALL be stable while out_ready=0.
REQ-024 The handshake on out_idx=NUM_PE-1 SHALL return the FSM to IDLE, drop out_valid, and pulse done for exactly one cycle (the first IDLE cycle).
REQ-025 start SHALL be accepted in the same cycle that done is high.
REQ-026 out_valid SHALL be 0 in IDLE and ACCUM.

Reset
REQ-027 rstn=0 SHALL asynchronously force IDLE, all counters 0, step counter 0, out_idx 0, out_valid 0, busy 0 and done 0, including mid-ACCUM or mid-DRAIN, with no partial results emitted after release.

Configuration
REQ-028 With SPIKE_COUNT_SATURATE_EN defined, a lane counter at 2^CNT_W-1 SHALL hold that value on further spikes.
REQ-029 Without SPIKE_COUNT_SATURATE_EN, a lane counter SHALL wrap modulo 2^CNT_W.

Structure
REQ-030 The state encoding (IDLE=0, ACCUM=1, DRAIN=2) and the default widths SHALL live in the shared package spiketpu_pkg.
REQ-031 The per-lane counter with clear, enable and the saturation option SHALL be a sub-module named spike_lane_counter, instantiated NUM_PE times.

Verification
REQ-032 Reset then num_steps=4 with in_spikes=8'hFF valid for 4 cycles and out_ready=1 -> 8 results idx 0..7, each count=4, then done for one cycle.
REQ-033 num_steps=3 with in_spikes 8'h01, 8'h03, 8'h81, and in_valid low for 2 cycles in between -> counts lane0=3, lane1=1, lane7=1, all other lanes 0.
REQ-034 DRAIN with out_ready toggling 1,0,0,1 -> out_idx/out_count held during stalls, exactly 8 transfers, and no duplicate or skipped idx.
REQ-035 CNT_W=8, num_steps=300, lane0 spiking every step -> 255 with SPIKE_COUNT_SATURATE_EN and 44 without.
REQ-036 rstn pulsed low after 2 of 5 steps, then a new start with num_steps=2 and all-ones spikes -> all counts=2, with no stale data.
REQ-037 num_steps=0 -> DRAIN entered with all counts 0; start pulsed during ACCUM -> ignored, and the window length is unchanged.
